mc_controller: RTL
==================

# mc_controller

Multi-cycle successor to the single-cycle MIPS controller. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same datapath control fields. Instruction and data memory are reached through ready handshakes, so memories may insert wait states. It adds addi overflow write suppression, illegal-opcode trapping and a retired-instruction counter, and sits between the instruction register and the shared multi-cycle datapath.

## Interface
- NFLAG_W, 32, width of the NFlag input
- FLAG_BIT_ZERO, 0, index of the ALU zero bit in NFlag
- FLAG_BIT_OVERFLOW, 1, index of the ALU overflow bit in NFlag
- CNT_W, 32, width of retired_cnt
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  from IR; stable after IRWr
- funct  in  6  from IR
- NFlag  in  NFLAG_W  ALU flags; combinational in the same cycle as ALUOp
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory access completes this cycle
- imem_req  out  1  instruction fetch request
- IRWr, PCWr, RegWr, MemWr, MemRd, ALUSrc  out  1 each  datapath strobes and selects
- RegDst, Mem2Reg, NPCSel, EXTOp, FlagOp  out  2 each
- ALUOp  out  3
- illegal  out  1  one-cycle pulse: undecodable instruction skipped
- retired_cnt  out  CNT_W  count of completed instructions, illegal ones included

## Operation
- Field encodings:
  - RegDst: RT=0, RD=1, RA=2
  - Mem2Reg: ALU=0, RAM=1, RET=2
  - NPCSel: PC+4=0, BEQ=1, J=2, REG=3
  - EXTOp: ZERO=0, SIGN=1, LUI=2
  - ALUOp: ADD=0, SUB=1, OR=2, LESS=3, B=4
  - FlagOp: DIS=0, SET=1
- Supported: addu, subu, slt, jr, ori, lw, sw, beq, lui, j, addi, addiu, jal.
- addi and addiu use SIGN extension. ori uses ZERO. lw and sw use SIGN.
- States are FETCH, DECODE, EXEC, MEM and WB, encoded 0–4. Control outputs are Moore, decoded from the state and the held opcode/funct.
- Paths through the states:
  - R-type, ori, lui, addi, addiu: F → D → E → WB
  - lw: F → D → E → MEM → WB
  - sw: F → D → E → MEM
  - beq and jr: F → D → E
  - j and jal: F → D
- PCWr pulses exactly once per instruction, in its last state, with NPCSel valid in that cycle.
  - beq selects BEQ if NFlag[FLAG_BIT_ZERO] is 1 in EXEC, otherwise PC+4.
  - j and jal select J; jr selects REG; all other instructions select PC+4.
- jal asserts RegWr with RegDst=RA and Mem2Reg=RET in DECODE.
- In EXEC, ovf_q captures NFlag[FLAG_BIT_OVERFLOW] when FlagOp=SET (addi only), and is cleared otherwise. For addi, WB drives RegWr = ~ovf_q.
- Opcode/funct not in the supported set: DECODE pulses illegal and PCWr (PC+4), all other strobes stay 0, next state is FETCH.
- retired_cnt increments on every PCWr cycle and wraps modulo 2^CNT_W.

## Timing
- Reset (rst_n low, asynchronous):
  - state becomes FETCH; retired_cnt and ovf_q become 0.
  - All outputs are forced to 0 combinationally while rst_n is low.
- The first imem_req is driven in the first cycle after rst_n rises.
- FETCH:
  - imem_req is held high until imem_ready.
  - IRWr=1 only in the cycle where imem_ready=1; FETCH → DECODE on that cycle.
- MEM:
  - MemRd (lw) or MemWr (sw) is held high until dmem_ready, together with stable ALUOp, ALUSrc and EXTOp.
  - Advance on dmem_ready.
- Minimum latency with zero wait states:
  - j and jal: 2 cycles
  - beq and jr: 3 cycles
  - ALU instructions and sw: 4 cycles
  - lw: 5 cycles
- Each wait cycle adds exactly one cycle. A ready signal outside FETCH/MEM is ignored.
- Reset mid-instruction abandons it: no PCWr, no count.
- Strobes that are not asserted drive 0. Unused select fields drive 0.

## Structure
- All encodings, opcode/funct constants and state codes live in the shared macro.v, extended with the state, MemRd and IRWr codes.
- Sub-module mc_decode (combinational): opcode/funct in; one-hot instruction class plus illegal out. The FSM and counter stay in mc_controller.

## Test plan
- Reset, then addu (opcode 0, funct 0x21) with imem_ready=1 → IRWr in cycle 1; in cycle 4: RegWr=1, RegDst=1, PCWr=1, NPCSel=0; retired_cnt=1.
- lw with imem_ready low 2 cycles and dmem_ready low 3 cycles → MemRd held 4 cycles, Mem2Reg=1 in WB, total 10 cycles.
- beq with NFlag zero bit =1, then repeated with it =0 → EXEC PCWr=1 with NPCSel=1, then NPCSel=0; RegWr=0 and MemWr=0 throughout.
- addi with overflow bit =1 in EXEC → FlagOp=1 in EXEC, RegWr=0 in WB, PCWr=1; with overflow =0 → RegWr=1.
- opcode 0x3F → illegal=1 and PCWr=1 in DECODE, back to FETCH, retired_cnt increments; then jal → RegWr=1, RegDst=2, Mem2Reg=2, NPCSel=2 in cycle 2.
- Assert rst_n low during the MEM wait of sw → outputs 0 immediately; after release, FETCH with imem_req=1; retired_cnt=0; with CNT_W=4, 16 retirements → wraps to 0.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: state codes, field encodings, opcode/funct constants and decode types
package mc_controller_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_RAM = 2'd1, M2R_RET = 2'd2;
  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BEQ = 2'd1, NPC_J = 2'd2, NPC_REG = 2'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
  localparam logic [1:0] FLAG_DIS = 2'd0, FLAG_SET = 2'd1;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LESS = 3'd3, ALU_B = 3'd4;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23, F_SLT = 6'h2A;
  typedef struct packed {
    logic addu, subu, slt, jr, ori, lw, sw, beq, lui, j, addi, addiu, jal;
  } ins_t;
  typedef struct packed {
    logic       imem_req, irwr, pcwr, regwr, memwr, memrd, alusrc;
    logic [1:0] regdst, mem2reg, npcsel, extop, flagop;
    logic [2:0] aluop;
    logic       illegal;
  } ctl_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: opcode/funct to one-hot instruction class; illegal when nothing matches
module mc_decode
  import mc_controller_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ins_t       ins,
  output logic       illegal
);
  logic r;
  assign r = opcode == OP_RTYPE;
  always_comb begin
    ins       = '0;
    ins.addu  = r && funct == F_ADDU;
    ins.subu  = r && funct == F_SUBU;
    ins.slt   = r && funct == F_SLT;
    ins.jr    = r && funct == F_JR;
    ins.ori   = opcode == OP_ORI;
    ins.lw    = opcode == OP_LW;
    ins.sw    = opcode == OP_SW;
    ins.beq   = opcode == OP_BEQ;
    ins.lui   = opcode == OP_LUI;
    ins.j     = opcode == OP_J;
    ins.addi  = opcode == OP_ADDI;
    ins.addiu = opcode == OP_ADDIU;
    ins.jal   = opcode == OP_JAL;
  end
  assign illegal = ~|ins;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM with memory handshakes, addi overflow
// write suppression, illegal-opcode skipping and a retired-instruction counter.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int NFLAG_W           = 32,
  parameter int FLAG_BIT_ZERO     = 0,
  parameter int FLAG_BIT_OVERFLOW = 1,
  parameter int CNT_W             = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [NFLAG_W-1:0] NFlag,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               IRWr,
  output logic               PCWr,
  output logic               RegWr,
  output logic               MemWr,
  output logic               MemRd,
  output logic               ALUSrc,
  output logic [1:0]         RegDst,
  output logic [1:0]         Mem2Reg,
  output logic [1:0]         NPCSel,
  output logic [1:0]         EXTOp,
  output logic [1:0]         FlagOp,
  output logic [2:0]         ALUOp,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired_cnt
);
  state_t state, nxt;
  ins_t   ins;
  ctl_t   c;
  logic   bad, ovf_q, zero, rt, imm, jmp, unused_flags;
  mc_decode u_dec (.opcode(opcode), .funct(funct), .ins(ins), .illegal(bad));
  assign zero         = NFlag[FLAG_BIT_ZERO];
  assign unused_flags = ^NFlag;
  assign rt           = ins.addu | ins.subu | ins.slt;
  assign imm          = ins.ori | ins.lui | ins.addi | ins.addiu | ins.lw | ins.sw;
  assign jmp          = ins.j | ins.jal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      ovf_q       <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_EXEC) ovf_q <= ins.addi & NFlag[FLAG_BIT_OVERFLOW];
      if (c.pcwr) retired_cnt <= retired_cnt + 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    c   = '0;
    case (state)
      S_FETCH: begin
        nxt        = imem_ready ? S_DECODE : S_FETCH;
        c.imem_req = 1'b1;
        c.irwr     = imem_ready;
      end
      S_DECODE: begin
        nxt       = (bad || jmp) ? S_FETCH : S_EXEC;
        c.pcwr    = bad | jmp;
        c.npcsel  = jmp ? NPC_J : NPC_PC4;
        c.regwr   = ins.jal;
        c.regdst  = ins.jal ? RD_RA : RD_RT;
        c.mem2reg = ins.jal ? M2R_RET : M2R_ALU;
        c.illegal = bad;
      end
      S_EXEC: begin
        nxt      = (ins.beq || ins.jr) ? S_FETCH : (ins.lw || ins.sw) ? S_MEM : S_WB;
        c.aluop  = (ins.subu || ins.beq) ? ALU_SUB : ins.slt ? ALU_LESS :
                   ins.ori ? ALU_OR : ins.lui ? ALU_B : ALU_ADD;
        c.alusrc = imm;
        c.extop  = ins.lui ? EXT_LUI : (imm && !ins.ori) ? EXT_SIGN : EXT_ZERO;
        c.flagop = ins.addi ? FLAG_SET : FLAG_DIS;
        c.pcwr   = ins.beq | ins.jr;
        c.npcsel = ins.jr ? NPC_REG : (ins.beq && zero) ? NPC_BEQ : NPC_PC4;
      end
      S_MEM: begin
        nxt      = !dmem_ready ? S_MEM : ins.lw ? S_WB : S_FETCH;
        c.memrd  = ins.lw;
        c.memwr  = ins.sw;
        c.aluop  = ALU_ADD;
        c.alusrc = 1'b1;
        c.extop  = EXT_SIGN;
        c.pcwr   = ins.sw & dmem_ready;
      end
      S_WB: begin
        nxt       = S_FETCH;
        c.pcwr    = 1'b1;
        c.regwr   = !(ins.addi && ovf_q);
        c.regdst  = rt ? RD_RD : RD_RT;
        c.mem2reg = ins.lw ? M2R_RAM : M2R_ALU;
      end
      default: nxt = S_FETCH;
    endcase
  end
  // reset must blank every control line immediately, not at the next edge
  assign {imem_req, IRWr, PCWr, RegWr, MemWr, MemRd, ALUSrc, RegDst, Mem2Reg,
          NPCSel, EXTOp, FlagOp, ALUOp, illegal} = rst_n ? c : '0;
endmodule
